// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection with exception vectoring, EX redirect,
// stall hold and call/return prediction through a circular return-address stack.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h0000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall_i,
    input  logic                           exc_req_i,
    input  logic                           redirect_i,
    input  logic [WIDTH-1:0]               redirect_pc_i,
    input  logic                           call_i,
    input  logic [WIDTH-1:0]               call_target_i,
    input  logic                           ret_i,
    output logic [WIDTH-1:0]               pc_o,
    output logic [WIDTH-1:0]               pc_plus4_o,
    output logic [WIDTH-1:0]               epc_o,
    output logic [$clog2(RAS_DEPTH):0]     ras_count_o,
    output logic                           ras_empty_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic             push;
    logic [WIDTH-1:0] pc_plus4;

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    assign pc_plus4 = pc_q + WIDTH'(4);

    // Strict priority: exception, redirect, stall, call, return, sequential.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        count_d = count_q;
        tos_d   = tos_q;
        push    = 1'b0;
        if (exc_req_i) begin
            pc_d    = align(EXC_VECTOR);
            epc_d   = pc_q;
            count_d = '0;
        end else if (redirect_i) begin
            pc_d = align(redirect_pc_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (call_i) begin
            pc_d    = align(call_target_i);
            push    = 1'b1;
            tos_d   = tos_q + PTR_W'(1);
            count_d = (count_q == CNT_W'(RAS_DEPTH)) ? count_q : count_q + CNT_W'(1);
        end else if (ret_i && (count_q != '0)) begin
            pc_d    = align(ras_q[tos_q]);
            tos_d   = tos_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= align(RESET_VECTOR);
            epc_q   <= '0;
            count_q <= '0;
            tos_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            count_q <= count_d;
            tos_q   <= tos_d;
        end
    end

    // Stack storage needs no reset; a full stack simply overwrites its oldest slot.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ras_q[tos_d] <= pc_plus4;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign epc_o       = epc_q;
    assign ras_count_o = count_q;
    assign ras_empty_o = (count_q == '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, stall/redirect, exception,
// call/return, stack overflow, wrap-around, call/ret priority and async reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, exc_req, redirect, call, ret;
    logic [31:0] redirect_pc, call_target;
    logic [31:0] pc, pc_plus4, epc;
    logic [2:0]  ras_count;
    logic        ras_empty;

    int compared = 0;
    int mismatched = 0;

    pc_unit #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h180), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .stall_i(stall), .exc_req_i(exc_req), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .call_i(call), .call_target_i(call_target),
        .ret_i(ret),
        .pc_o(pc), .pc_plus4_o(pc_plus4), .epc_o(epc),
        .ras_count_o(ras_count), .ras_empty_o(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        stall = 0; exc_req = 0; redirect = 0; call = 0; ret = 0;
        redirect_pc = '0; call_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPc(input string tag, input logic [31:0] expPc, input logic [31:0] expCount);
        check({tag, ".pc"}, pc, expPc);
        check({tag, ".count"}, {29'd0, ras_count}, expCount);
    endtask

    initial begin
        idle();
        reset = 1;
        #12;
        check("reset.pc", pc, 32'h0);
        check("reset.epc", epc, 32'h0);
        check("reset.count", {29'd0, ras_count}, 0);
        check("reset.empty", {31'd0, ras_empty}, 1);
        check("reset.pc_plus4", pc_plus4, 32'h4);

        // Sequential fetch
        @(negedge clk); reset = 0;
        step(); checkPc("seq1", 32'h4, 0);
        step(); checkPc("seq2", 32'h8, 0);
        step(); checkPc("seq3", 32'hC, 0);
        check("seq.pc_plus4", pc_plus4, 32'h10);
        step(); checkPc("seq4", 32'h10, 0);

        // Stall hold, then redirect overrides stall with alignment
        stall = 1;
        step(); check("stall1", pc, 32'h10);
        step(); check("stall2", pc, 32'h10);
        step(); check("stall3", pc, 32'h10);
        redirect = 1; redirect_pc = 32'h203;
        step(); checkPc("redir_stall", 32'h200, 0);
        idle();

        // Build two stack entries, then exception with simultaneous redirect
        call = 1; call_target = 32'h30;
        step(); checkPc("pre_exc1", 32'h30, 1);
        call_target = 32'h40;
        step(); checkPc("pre_exc2", 32'h40, 2);
        idle();
        exc_req = 1; redirect = 1; redirect_pc = 32'h888;
        step(); checkPc("exc", 32'h180, 0);
        check("exc.epc", epc, 32'h40);
        check("exc.empty", {31'd0, ras_empty}, 1);
        idle();

        // Call / return
        redirect = 1; redirect_pc = 32'h100;
        step(); checkPc("to100", 32'h100, 0);
        idle();
        call = 1; call_target = 32'h303;
        step(); checkPc("call", 32'h300, 1);
        idle(); ret = 1;
        step(); checkPc("ret", 32'h104, 0);
        step(); checkPc("ret_empty", 32'h108, 0);
        check("ret_empty.epc", epc, 32'h40);
        idle();

        // Overflow: five nested calls into a 4-deep stack
        redirect = 1; redirect_pc = 32'h0;
        step(); checkPc("to0", 32'h0, 0);
        idle(); call = 1;
        call_target = 32'h10; step(); checkPc("ovf_call1", 32'h10, 1);
        call_target = 32'h20; step(); checkPc("ovf_call2", 32'h20, 2);
        call_target = 32'h30; step(); checkPc("ovf_call3", 32'h30, 3);
        call_target = 32'h40; step(); checkPc("ovf_call4", 32'h40, 4);
        call_target = 32'h50; step(); checkPc("ovf_call5", 32'h50, 4);
        idle(); ret = 1;
        step(); checkPc("ovf_ret1", 32'h44, 3);
        step(); checkPc("ovf_ret2", 32'h34, 2);
        step(); checkPc("ovf_ret3", 32'h24, 1);
        step(); checkPc("ovf_ret4", 32'h14, 0);
        step(); checkPc("ovf_ret5", 32'h18, 0);
        idle();

        // Wrap-around
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step(); checkPc("to_top", 32'hFFFF_FFFC, 0);
        check("top.pc_plus4", pc_plus4, 32'h0);
        idle();
        step(); checkPc("wrap", 32'h0, 0);

        // Call and ret together: call wins and pushes pc+4
        call = 1; ret = 1; call_target = 32'h500;
        step(); checkPc("call_ret", 32'h500, 1);
        idle(); ret = 1;
        step(); checkPc("call_ret.pop", 32'h4, 0);
        idle();

        // Async reset mid-stream discards a pending call
        call = 1; call_target = 32'h600;
        #3 reset = 1;
        #1;
        check("async.pc", pc, 32'h0);
        check("async.epc", epc, 32'h0);
        check("async.count", {29'd0, ras_count}, 0);
        step(); checkPc("async_hold", 32'h0, 0);
        idle();
        @(negedge clk); reset = 0;
        step(); checkPc("after_reset", 32'h4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
